// File: rtl/shift_capture.sv
// Serial-to-parallel capture with a two-stage buffer (shift register + output word).
// Optional even-parity framing is enabled by defining SHIFT_CAPTURE_PARITY_EN.
module shift_capture #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Shift_En,
    input  logic             Shift_In,
    input  logic             Abort,
    input  logic             Data_Ready,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Data_Valid,
    output logic             Busy,
    output logic             Overrun,
    output logic             Parity_Err
);

    localparam int CW = $clog2(WIDTH + 2);
`ifdef SHIFT_CAPTURE_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    count_r, count_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] data_out_r, data_out_s;
    logic             data_valid_r, data_valid_s;
    logic             overrun_r, overrun_s;
    logic             busy_r;
    logic             done_s;

`ifdef SHIFT_CAPTURE_PARITY_EN
    logic             parity_err_r, parity_err_s;

    // 1 when data plus received parity bit do not form even parity
    function automatic logic even_parity_err(input logic [WIDTH-1:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    // Next-state, shift, handshake and overrun decisions
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        shreg_s      = shreg_r;
        data_out_s   = data_out_r;
        data_valid_s = data_valid_r;
        overrun_s    = overrun_r;
        done_s       = 1'b0;
        word_s       = shreg_r;
`ifdef SHIFT_CAPTURE_PARITY_EN
        parity_err_s = parity_err_r;
`endif
        if (LSB_FIRST != 0) begin
            shifted_s = {Shift_In, shreg_r[WIDTH-1:1]};
        end else begin
            shifted_s = {shreg_r[WIDTH-2:0], Shift_In};
        end

        // A consume frees the output stage on this edge, even if a word also lands
        if (data_valid_r && Data_Ready) begin
            data_valid_s = 1'b0;
        end else begin
            data_valid_s = data_valid_r;
        end

        if (Abort) begin
            count_s   = {CW{1'b0}};
            shreg_s   = {WIDTH{1'b0}};
            overrun_s = 1'b0;
        end else if (Shift_En) begin
            done_s  = (count_r == LAST_CNT);
            count_s = done_s ? {CW{1'b0}} : (count_r + CW'(1));
`ifdef SHIFT_CAPTURE_PARITY_EN
            // The trailing parity bit is checked, not shifted in
            if (count_r < CW'(WIDTH)) begin
                shreg_s = shifted_s;
            end else begin
                shreg_s = shreg_r;
            end
            word_s = shreg_r;
`else
            shreg_s = shifted_s;
            word_s  = shifted_s;
`endif
            if (done_s) begin
                if (!data_valid_r || Data_Ready) begin
                    data_out_s   = word_s;
                    data_valid_s = 1'b1;
`ifdef SHIFT_CAPTURE_PARITY_EN
                    parity_err_s = even_parity_err(shreg_r, Shift_In);
`endif
                end else begin
                    overrun_s = 1'b1;
                end
            end else begin
                overrun_s = overrun_r;
            end
        end else begin
            count_s = count_r;
        end

        case (state_r)
            IDLE: begin
                if (!Abort && Shift_En && !done_s) begin
                    state_s = COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (Abort || done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = COLLECT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r      <= IDLE;
            count_r      <= {CW{1'b0}};
            shreg_r      <= {WIDTH{1'b0}};
            data_out_r   <= {WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
`ifdef SHIFT_CAPTURE_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            shreg_r      <= shreg_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            overrun_r    <= overrun_s;
            busy_r       <= (state_s == COLLECT);
`ifdef SHIFT_CAPTURE_PARITY_EN
            parity_err_r <= parity_err_s;
`endif
        end
    end

    assign Data_Out   = data_out_r;
    assign Data_Valid = data_valid_r;
    assign Busy       = busy_r;
    assign Overrun    = overrun_r;
`ifdef SHIFT_CAPTURE_PARITY_EN
    assign Parity_Err = parity_err_r;
`else
    assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_capture.sv
// Directed self-checking bench for shift_capture: one LSB-first and one MSB-first instance share stimulus.
module tb_shift_capture;

    logic       Clk = 1'b0;
    logic       Reset_n, Shift_En, Shift_In, Abort, Data_Ready;
    logic [7:0] dout_l, dout_m;
    logic       dv_l, dv_m, busy_l, busy_m, ovr_l, ovr_m, perr_l, perr_m;
    int         checks = 0;
    int         failures = 0;

    always #5 Clk = ~Clk;

    shift_capture #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
        .Clk(Clk), .Reset_n(Reset_n), .Shift_En(Shift_En), .Shift_In(Shift_In),
        .Abort(Abort), .Data_Ready(Data_Ready), .Data_Out(dout_l), .Data_Valid(dv_l),
        .Busy(busy_l), .Overrun(ovr_l), .Parity_Err(perr_l));

    shift_capture #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
        .Clk(Clk), .Reset_n(Reset_n), .Shift_En(Shift_En), .Shift_In(Shift_In),
        .Abort(Abort), .Data_Ready(Data_Ready), .Data_Out(dout_m), .Data_Valid(dv_m),
        .Busy(busy_m), .Overrun(ovr_m), .Parity_Err(perr_m));

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        Shift_En = 1'b1;
        Shift_In = b;
        tick();
        Shift_En = 1'b0;
        Shift_In = 1'b0;
    endtask

    // Sends d[0] first; the parity bit follows only when parity framing is built in
    task automatic send_word(input logic [7:0] d, input logic p);
        for (int i = 0; i < 8; i++) shift_bit(d[i]);
`ifdef SHIFT_CAPTURE_PARITY_EN
        shift_bit(p);
`else
        if (p === 1'bx) $display("note: unexpected parity argument");
`endif
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Shift_En = 1'b0; Shift_In = 1'b0; Abort = 1'b0; Data_Ready = 1'b0;
        tick();
        tick();
        if ({dout_l, dv_l, busy_l, ovr_l, perr_l} !== 12'h000) begin
            $display("FAIL reset_lsb got=%h exp=000", {dout_l, dv_l, busy_l, ovr_l, perr_l}); failures++; end
        checks++;
        if ({dout_m, dv_m, busy_m, ovr_m, perr_m} !== 12'h000) begin
            $display("FAIL reset_msb got=%h exp=000", {dout_m, dv_m, busy_m, ovr_m, perr_m}); failures++; end
        checks++;
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_bit_order();
        logic [7:0] d;
        d = 8'h4D;
        Data_Ready = 1'b1;
        shift_bit(d[0]);
        if (busy_l !== 1'b1) begin $display("FAIL busy_first_bit got=%b exp=1", busy_l); failures++; end
        checks++;
        for (int i = 1; i < 7; i++) shift_bit(d[i]);
        if (dv_l !== 1'b0) begin $display("FAIL early_valid got=%b exp=0", dv_l); failures++; end
        checks++;
        shift_bit(d[7]);
`ifdef SHIFT_CAPTURE_PARITY_EN
        if (dv_l !== 1'b0) begin $display("FAIL valid_before_parity got=%b exp=0", dv_l); failures++; end
        checks++;
        shift_bit(1'b0);
`endif
        if (dv_l !== 1'b1) begin $display("FAIL lsb_valid got=%b exp=1", dv_l); failures++; end
        checks++;
        if (dout_l !== 8'h4D) begin $display("FAIL lsb_first_data got=%h exp=4d", dout_l); failures++; end
        checks++;
        if (dout_m !== 8'hB2) begin $display("FAIL msb_first_data got=%h exp=b2", dout_m); failures++; end
        checks++;
        if (busy_l !== 1'b0) begin $display("FAIL busy_after_word got=%b exp=0", busy_l); failures++; end
        checks++;
        if (perr_l !== 1'b0) begin $display("FAIL perr_good_word got=%b exp=0", perr_l); failures++; end
        checks++;
        tick();
        if (dv_l !== 1'b0) begin $display("FAIL valid_one_cycle got=%b exp=0", dv_l); failures++; end
        checks++;
        if (dout_l !== 8'h4D) begin $display("FAIL data_hold_after_consume got=%h exp=4d", dout_l); failures++; end
        checks++;
    endtask

    task automatic test_gaps();
        logic [7:0] d;
        d = 8'h1E;
        Data_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            shift_bit(d[i]);
            if (i < 7) tick();
            if (i == 3) begin
                if (busy_l !== 1'b1 || dv_l !== 1'b0) begin
                    $display("FAIL gap_hold got=busy%b/valid%b exp=busy1/valid0", busy_l, dv_l); failures++; end
                checks++;
            end
        end
`ifdef SHIFT_CAPTURE_PARITY_EN
        tick();
        shift_bit(1'b0);
`endif
        if (dout_l !== 8'h1E || dv_l !== 1'b1) begin
            $display("FAIL gap_lsb_data got=%h/%b exp=1e/1", dout_l, dv_l); failures++; end
        checks++;
        if (dout_m !== 8'h78) begin $display("FAIL gap_msb_data got=%h exp=78", dout_m); failures++; end
        checks++;
        tick();
    endtask

    task automatic test_overrun();
        Data_Ready = 1'b0;
        send_word(8'h4D, 1'b0);
        if (dv_l !== 1'b1 || dout_l !== 8'h4D) begin
            $display("FAIL ovr_first_word got=%h/%b exp=4d/1", dout_l, dv_l); failures++; end
        checks++;
        shift_bit(1'b1);
        if (busy_l !== 1'b1 || dv_l !== 1'b1) begin
            $display("FAIL collect_while_valid got=busy%b/valid%b exp=1/1", busy_l, dv_l); failures++; end
        checks++;
        for (int i = 1; i < 8; i++) shift_bit(1'b1);
`ifdef SHIFT_CAPTURE_PARITY_EN
        shift_bit(1'b0);
`endif
        if (dout_l !== 8'h4D) begin $display("FAIL ovr_data_kept got=%h exp=4d", dout_l); failures++; end
        checks++;
        if (ovr_l !== 1'b1 || ovr_m !== 1'b1) begin $display("FAIL overrun_set got=%b%b exp=11", ovr_l, ovr_m); failures++; end
        checks++;
        Data_Ready = 1'b1;
        tick();
        Data_Ready = 1'b0;
        if (ovr_l !== 1'b1 || dv_l !== 1'b0) begin
            $display("FAIL overrun_sticky got=ovr%b/valid%b exp=1/0", ovr_l, dv_l); failures++; end
        checks++;
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        if (ovr_l !== 1'b0) begin $display("FAIL overrun_clear got=%b exp=0", ovr_l); failures++; end
        checks++;
        tick();
    endtask

    task automatic test_abort();
        Data_Ready = 1'b1;
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
        Shift_En = 1'b1; Shift_In = 1'b1; Abort = 1'b1;
        tick();
        Shift_En = 1'b0; Shift_In = 1'b0; Abort = 1'b0;
        if (busy_l !== 1'b0 || dv_l !== 1'b0) begin
            $display("FAIL abort_idle got=busy%b/valid%b exp=0/0", busy_l, dv_l); failures++; end
        checks++;
        for (int i = 0; i < 7; i++) shift_bit(1'b1);
        if (dv_l !== 1'b0) begin $display("FAIL abort_count_cleared got=%b exp=0", dv_l); failures++; end
        checks++;
        shift_bit(1'b1);
`ifdef SHIFT_CAPTURE_PARITY_EN
        shift_bit(1'b0);
`endif
        if (dv_l !== 1'b1 || dout_l !== 8'hFF || dout_m !== 8'hFF) begin
            $display("FAIL abort_next_word got=%h/%h/%b exp=ff/ff/1", dout_l, dout_m, dv_l); failures++; end
        checks++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        d = 8'h1E;
        Data_Ready = 1'b0;
        send_word(8'h4D, 1'b0);
        for (int i = 0; i < 7; i++) shift_bit(d[i]);
`ifdef SHIFT_CAPTURE_PARITY_EN
        shift_bit(d[7]);
        Data_Ready = 1'b1;
        shift_bit(1'b0);
`else
        Data_Ready = 1'b1;
        shift_bit(d[7]);
`endif
        Data_Ready = 1'b0;
        if (dv_l !== 1'b1 || dout_l !== 8'h1E || dout_m !== 8'h78) begin
            $display("FAIL b2b_load got=%h/%h/%b exp=1e/78/1", dout_l, dout_m, dv_l); failures++; end
        checks++;
        if (ovr_l !== 1'b0) begin $display("FAIL b2b_no_overrun got=%b exp=0", ovr_l); failures++; end
        checks++;
        Data_Ready = 1'b1;
        tick();
        if (dv_l !== 1'b0) begin $display("FAIL b2b_consume got=%b exp=0", dv_l); failures++; end
        checks++;
    endtask

    task automatic test_reset_mid_word();
        Data_Ready = 1'b1;
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        Reset_n = 1'b0; Shift_En = 1'b1; Shift_In = 1'b1; Abort = 1'b1;
        tick();
        if ({dout_l, dv_l, busy_l, ovr_l, perr_l, dv_m, busy_m} !== 14'h0000) begin
            $display("FAIL reset_mid_word got=%h exp=0000", {dout_l, dv_l, busy_l, ovr_l, perr_l, dv_m, busy_m}); failures++; end
        checks++;
        Reset_n = 1'b1; Shift_En = 1'b0; Shift_In = 1'b0; Abort = 1'b0;
        send_word(8'h4D, 1'b0);
        if (dout_l !== 8'h4D || dv_l !== 1'b1) begin
            $display("FAIL after_reset_word got=%h/%b exp=4d/1", dout_l, dv_l); failures++; end
        checks++;
        tick();
    endtask

    task automatic test_parity();
        logic exp_err;
`ifdef SHIFT_CAPTURE_PARITY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        Data_Ready = 1'b1;
        send_word(8'h4D, 1'b1);
        if (perr_l !== exp_err || dout_l !== 8'h4D) begin
            $display("FAIL parity_bad got=%b/%h exp=%b/4d", perr_l, dout_l, exp_err); failures++; end
        checks++;
        tick();
        send_word(8'h4D, 1'b0);
        if (perr_l !== 1'b0 || perr_m !== 1'b0) begin
            $display("FAIL parity_good got=%b%b exp=00", perr_l, perr_m); failures++; end
        checks++;
        tick();
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_gaps();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_reset_mid_word();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
